// File: rtl/sqrt_recon_if.sv
// rtl/sqrt_recon_if.sv - operand/result bundle between a sqrt-result source and the reconstructor
interface sqrt_recon_if #(
    parameter int N = 16
);
    logic           start;
    logic [N-1:0]   root;
    logic [N:0]     reminder;
    logic           busy;
    logic           complete;
    logic [2*N-1:0] a;
    logic           range_err;

    modport master (
        output start, root, reminder,
        input  busy, complete, a, range_err
    );

    modport slave (
        input  start, root, reminder,
        output busy, complete, a, range_err
    );
endinterface

// File: rtl/sqrt_recon.sv
// rtl/sqrt_recon.sv - rebuilds a = root*root + reminder with a bit-serial shift-add multiplier
module sqrt_recon #(
    parameter int N = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    sqrt_recon_if.slave bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;   // also serves as the latched root for the range test
    logic [N:0]      rem_q, rem_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  a_q, a_d;
    logic            err_q, err_d;

    // State and datapath registers; reset wins over any operation in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            err_q    <= err_d;
        end
    end

    // Next state: accept in IDLE/DONE, one multiplier bit per MUL cycle, final add in ADD
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    mcand_d  = bus.root;
                    mplier_d = bus.root;
                    rem_d    = bus.reminder;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                if (mcand_q[0]) begin
                    acc_d = acc_q + ({{N{1'b0}}, mplier_q} << cnt_q);
                end
                mcand_d = mcand_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                // An illegal remainder may carry out of 2N bits; the wrap is intentional
                a_d     = acc_q + {{(N-1){1'b0}}, rem_q};
                err_d   = rem_q > {mplier_q, 1'b0};
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy      = (state_q == S_MUL) || (state_q == S_ADD);
    assign bus.complete  = (state_q == S_DONE);
    assign bus.a         = a_q;
    assign bus.range_err = err_q;
endmodule

// File: tb/tb_sqrt_recon.sv
// tb/tb_sqrt_recon.sv - scoreboard bench for sqrt_recon
module tb_sqrt_recon;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sqrt_recon_if #(.N(N)) bus ();
    sqrt_recon #(.N(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;
    logic [32:0] sb_q[$];
    logic [31:0] prev_a = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [32:0] model(input logic [15:0] r, input logic [16:0] m);
        logic [63:0] s;
        s = 64'(r) * 64'(r) + 64'(m);
        return {(m > {r, 1'b0}), s[31:0]};
    endfunction

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        logic [15:0] r, t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if (64'(t) * 64'(t) <= 64'(x)) r = t;
        end
        return r;
    endfunction

    // Scoreboard: pop and compare on every rising edge of complete
    logic prev_complete = 1'b0;
    always @(negedge clk) begin
        logic [32:0] e;
        if (bus.complete && !prev_complete) begin
            chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("result_a", 64'(bus.a), 64'(e[31:0]));
                chk("range_err", 64'(bus.range_err), 64'(e[32]));
            end
        end
        prev_complete <= bus.complete;
    end

    // Start one operation from a negedge; optionally re-pulse start mid-flight at cycle ign_at
    task automatic do_op(input logic [15:0] r, input logic [16:0] m, input int ign_at);
        int cyc, bsy;
        logic [32:0] e;
        e = model(r, m);
        bus.root = r;
        bus.reminder = m;
        bus.start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.root = 16'($urandom);
        bus.reminder = 17'($urandom);
        chk("start_drops_complete", 64'(bus.complete), 64'd0);
        chk("a_holds_old", 64'(bus.a), 64'(prev_a));
        cyc = 0;
        bsy = 0;
        while (!bus.complete && cyc < 100) begin
            if (bus.busy) bsy++;
            bus.start = (ign_at != 0 && cyc == ign_at);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk("latency", 64'(cyc), 64'd17);
        chk("busy_cycles", 64'(bsy), 64'd17);
        prev_a = e[31:0];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal;
    end

    initial begin
        int cyc;
        logic [31:0] x;
        logic [15:0] r;
        logic [31:0] sq;
        bus.start = 1'b0;
        bus.root = '0;
        bus.reminder = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_complete", 64'(bus.complete), 64'd0);
        chk("rst_a", 64'(bus.a), 64'd0);
        chk("rst_err", 64'(bus.range_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'hFFFF, 17'h1FFFE, 0);
        do_op(16'h1234, 17'h0, 0);
        do_op(16'h0, 17'h0, 0);
        do_op(16'h3, 17'h7, 0);
        do_op(16'hFFFF, 17'h1FFFF, 0);

        // Reset mid-operation
        bus.root = 16'hABCD;
        bus.reminder = 17'h55;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_complete", 64'(bus.complete), 64'd0);
        chk("midrst_a", 64'(bus.a), 64'd0);
        chk("midrst_err", 64'(bus.range_err), 64'd0);
        rst = 1'b0;
        prev_a = '0;
        @(negedge clk);
        do_op(16'hBEEF, 17'h100, 0);

        // Ignored re-pulse of start during MUL
        do_op(16'h00C3, 17'h0011, 5);

        // complete holds in DONE, then a restart from DONE
        repeat (3) begin
            @(negedge clk);
            chk("done_hold", 64'(bus.complete), 64'd1);
        end
        do_op(16'h7777, 17'h0EEEE, 0);

        // Start held high: back-to-back operations, three results
        bus.root = 16'h00FF;
        bus.reminder = 17'h5;
        bus.start = 1'b1;
        repeat (3) sb_q.push_back(model(16'h00FF, 17'h5));
        cyc = 0;
        @(negedge clk);
        while (!bus.complete && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_first_latency", 64'(cyc), 64'd17);
        for (int j = 0; j < 2; j++) begin
            cyc = 1;
            @(negedge clk);
            chk("hold_done_1cyc", 64'(bus.complete), 64'd0);
            while (!bus.complete && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            chk("hold_period", 64'(cyc), 64'd18);
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk("hold_release_stays_done", 64'(bus.complete), 64'd1);
        prev_a = model(16'h00FF, 17'h5);

        // Round trip against an integer square root
        x = 32'hFFFFFFFF;
        for (int i = 0; i < 64; i++) begin
            r = isqrt(x);
            sq = r * r;
            do_op(r, 17'(x - sq), 0);
            chk("roundtrip_a", 64'(bus.a), 64'(x));
            chk("roundtrip_err", 64'(bus.range_err), 64'd0);
            x = x + 32'd2;
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
